// File: rtl/demux_1ton_fifo.sv
// 1-to-NUM_OUT stream demux: each output lane has its own first-word-fall-through FIFO
// with valid/ready backpressure. Routing is by selector or by hardware round-robin.
module demux_1ton_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_OUT    = 4,
   parameter int SEL_WIDTH  = 2,
   parameter int DEPTH      = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [DATA_WIDTH-1:0]         dataIn,
   input  logic                          validIn,
   output logic                          readyIn,
   input  logic [SEL_WIDTH-1:0]          selector,
   input  logic                          rrMode,
   output logic [NUM_OUT*DATA_WIDTH-1:0] dataOut,
   output logic [NUM_OUT-1:0]            validOut,
   input  logic [NUM_OUT-1:0]            readyOut,
   output logic                          errSel
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0]     FULL_CNT  = CNT_W'(DEPTH);
   localparam logic [SEL_WIDTH:0]   NUM_OUT_X = (SEL_WIDTH + 1)'(NUM_OUT);
   localparam logic [SEL_WIDTH-1:0] LAST_CH   = SEL_WIDTH'(NUM_OUT - 1);

   logic [SEL_WIDTH-1:0]  rr_ptr;
   logic [SEL_WIDTH-1:0]  target;
   logic                  target_ok;
   logic                  accept;
   logic [NUM_OUT-1:0]    target_hot;
   logic [NUM_OUT-1:0]    full;
   logic [NUM_OUT-1:0]    push;
   logic [NUM_OUT-1:0]    pop;
   logic [PTR_W-1:0]      wr_ptr [NUM_OUT];
   logic [PTR_W-1:0]      rd_ptr [NUM_OUT];
   logic [CNT_W-1:0]      count  [NUM_OUT];
   logic [DATA_WIDTH-1:0] mem    [NUM_OUT][DEPTH];

   // Full is taken from the registered count only, so a same-cycle pop never
   // opens the input path of a full lane.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path leaves a latch.
      dataOut    = '0;
      target_hot = '0;
      full       = '0;
      validOut   = '0;
      pop        = '0;
      target     = rrMode ? rr_ptr : selector;
      target_ok  = {1'b0, target} < NUM_OUT_X;
      for (int i = 0; i < NUM_OUT; i++) begin
         target_hot[i] = target_ok && (target == SEL_WIDTH'(i));
         full[i]       = (count[i] == FULL_CNT);
         validOut[i]   = (count[i] != '0);
         pop[i]        = validOut[i] && readyOut[i];
         if (validOut[i])
            dataOut[i*DATA_WIDTH +: DATA_WIDTH] = mem[i][rd_ptr[i]];
      end
      readyIn = !target_ok || ((target_hot & full) == '0);
      accept  = validIn && readyIn;
      push    = target_hot & {NUM_OUT{accept}};
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr <= '0;
         errSel <= 1'b0;
         for (int i = 0; i < NUM_OUT; i++) begin
            wr_ptr[i] <= '0;
            rd_ptr[i] <= '0;
            count[i]  <= '0;
         end
      end else begin
         if (accept && !target_ok)
            errSel <= 1'b1;
         if (accept && rrMode)
            rr_ptr <= (rr_ptr == LAST_CH) ? '0 : rr_ptr + 1'b1;
         for (int i = 0; i < NUM_OUT; i++) begin
            if (push[i])
               wr_ptr[i] <= wr_ptr[i] + 1'b1;
            if (pop[i])
               rd_ptr[i] <= rd_ptr[i] + 1'b1;
            case ({push[i], pop[i]})
               2'b10:   count[i] <= count[i] + 1'b1;
               2'b01:   count[i] <= count[i] - 1'b1;
               default: count[i] <= count[i];
            endcase
         end
      end
   end

   // NOTE: the storage array has no reset; count gates validOut/dataOut so stale words never show.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_OUT; i++) begin
         if (push[i] && !reset)
            mem[i][wr_ptr[i]] <= dataIn;
      end
   end

endmodule

// File: doc/demux_1ton_fifo.md
Name: demux_1toN_fifo

Overview:
Parametrised successor to the team's 2-way valid-qualified demux. It routes one input stream to NUM_OUT output channels. Each channel has its own first-word-fall-through FIFO and a valid/ready handshake, so backpressure is supported. Routing is either by explicit selector or by hardware round-robin. It sits between a packet source and NUM_OUT independent consumer lanes.

Parameters:
DATA_WIDTH, 8, width of each data word
NUM_OUT, 4, number of output channels (>=2)
SEL_WIDTH, 2, selector width; must satisfy 2**SEL_WIDTH >= NUM_OUT
DEPTH, 4, per-channel FIFO entries (power of two, >=2)

Ports:
clk  input  1  single clock, all logic on rising edge
reset  input  1  synchronous, active-high; clears all state on the next rising edge
dataIn  input  DATA_WIDTH  input word
validIn  input  1  input word valid
readyIn  output  1  block can accept the word presented this cycle
selector  input  SEL_WIDTH  target channel when rrMode=0
rrMode  input  1  0 = selector routing, 1 = round-robin routing
dataOut  output  NUM_OUT*DATA_WIDTH  channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
validOut  output  NUM_OUT  channel i head word valid
readyOut  input  NUM_OUT  consumer i accepts its head word
errSel  output  1  sticky flag: a word was addressed to a nonexistent channel

Behaviour:
- Reset (reset=1 at a clock edge):
  - all FIFOs are emptied and read/write pointers cleared.
  - validOut=0, dataOut=0, errSel=0, round-robin pointer rrPtr=0.
  - Reset is honoured mid-transfer; in-flight words are discarded. readyIn still follows the combinational rules below during reset, but no push occurs.
- Target channel t:
  - rrMode=0: t = selector.
  - rrMode=1: t = rrPtr.
- readyIn (combinational):
  - rrMode=0 and selector >= NUM_OUT: readyIn=1 (invalid target; the word is sunk).
  - Otherwise: readyIn = NOT full[t].
  - full[t] is evaluated from the registered count only. A same-cycle pop on a full FIFO does not raise readyIn (no bypass).
- Push: an accept occurs when validIn=1 and readyIn=1.
  - Valid target: the word is written to FIFO t at the edge.
  - Invalid target: the word is dropped and errSel is set to 1 at the edge. errSel stays 1 until reset.
- Round-robin pointer:
  - Advances by 1 on each accepted word while rrMode=1, wrapping from NUM_OUT-1 to 0.
  - Holds its value while rrMode=0 or when no word is accepted.
  - Switching rrMode does not disturb FIFO contents.
- Latency: a word accepted at edge k is visible on dataOut/validOut for its channel immediately after edge k if that FIFO was empty. Otherwise it appears behind older entries in order.
- Output side, per channel i:
  - validOut[i] = (count[i] != 0).
  - dataOut slice i = head entry when valid, else all zeros.
  - Pop occurs at an edge where validOut[i]=1 and readyOut[i]=1.
  - readyOut[i] while validOut[i]=0 has no effect.
- Counts, per channel, updated at each edge:
  - push only: count+1.
  - pop only: count-1.
  - push and pop together (non-full, non-empty): count unchanged, both pointers advance.
  - Pointers wrap modulo DEPTH.
  - count ranges 0..DEPTH and needs clog2(DEPTH)+1 bits.
- Channels are fully independent: a stalled channel blocks the input only when it is the current target.
- No data loss except the invalid-selector drop. No duplication. Per-channel order is preserved.

Test Plan:
- Reset, then hold validIn=0 for 3 cycles -> validOut=0000, dataOut all zero, readyIn=1, errSel=0.
- rrMode=0, selector=2, send 0xA5 with readyOut=1111 -> validOut[2]=1 and dataOut[2]=0xA5 in the cycle after the accept edge; popped on the next edge; other channels stay idle.
- rrMode=0, selector=1, readyOut[1]=0, send 5 words 0x10..0x14 -> first 4 accepted and readyIn=0 on the 5th. Raise readyOut[1] -> 0x10,0x11,0x12,0x13 emerge in order, then 0x14 is accepted once count[1] < 4.
- rrMode=1, readyOut=1111, send 0x01..0x06 -> routed to channels 0,1,2,3,0,1; rrPtr=2 afterwards. Insert a validIn=0 cycle and confirm rrPtr holds.
- NUM_OUT=3, SEL_WIDTH=2, rrMode=0, selector=3, send 0xFF -> readyIn=1, no channel written, errSel=1 and remaining 1 after 10 idle cycles. Then assert reset -> errSel=0.
- Channel 0 holding 3 entries: simultaneous push (selector=0) and pop on the same edge -> count stays 3 and head advances. Assert reset mid-burst -> all validOut=0 on the next cycle.
